// File: rtl/flex_pts_serializer.sv
// flex_pts_serializer: parallel-to-serial shifter with per-bit hold time, stall, done pulse; optional even parity via FLEX_PTS_PARITY_EN
// Ports: clk, rst (sync, active-high), load_valid/load_ready/parallel_in (word handshake),
//        shift_enable (advance enable), serial_out (registered), busy, done (one-cycle pulse).
module flex_pts_serializer #(
  parameter int NUM_BITS     = 8,
  parameter bit SHIFT_MSB    = 1'b1,
  parameter int CLKS_PER_BIT = 4,
  parameter bit IDLE_LEVEL   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [NUM_BITS-1:0] parallel_in,
  input  logic                shift_enable,
  output logic                serial_out,
  output logic                busy,
  output logic                done
);
  localparam int BW = $clog2(NUM_BITS);
  localparam int PW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
`ifdef FLEX_PTS_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  logic par_q, par_d;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif
  state_t state_q, state_d;
  logic [NUM_BITS-1:0] sr_q, sr_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic so_q, so_d, done_q, done_d;
  logic accept, tick, last_bit;
  function automatic logic first_bit(input logic [NUM_BITS-1:0] x);
    return SHIFT_MSB ? x[NUM_BITS-1] : x[0];
  endfunction
  function automatic logic [NUM_BITS-1:0] shifted(input logic [NUM_BITS-1:0] x);
    return SHIFT_MSB ? {x[NUM_BITS-2:0], IDLE_LEVEL} : {IDLE_LEVEL, x[NUM_BITS-1:1]};
  endfunction
  assign accept   = load_valid && load_ready;
  assign tick     = shift_enable && pcnt_q == PW'(CLKS_PER_BIT - 1);
  assign last_bit = bcnt_q == BW'(NUM_BITS - 1);
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && accept) state_d = SHIFT;
`ifdef FLEX_PTS_PARITY_EN
    if (state_q == SHIFT && tick && last_bit) state_d = PARITY;
    if (state_q == PARITY && tick) state_d = IDLE;
`else
    if (state_q == SHIFT && tick && last_bit) state_d = IDLE;
`endif
  end
  always_comb begin
    busy       = state_q != IDLE;
    load_ready = state_q == IDLE && !rst;
  end
  assign serial_out = so_q;
  assign done       = done_q;
  // The shift register holds only the bits not yet driven: the first bit goes
  // straight to serial_out on accept, so each advance pops the next one.
  always_comb begin
    sr_d   = sr_q;
    bcnt_d = bcnt_q;
    pcnt_d = pcnt_q;
    so_d   = so_q;
    done_d = 1'b0;
`ifdef FLEX_PTS_PARITY_EN
    par_d  = par_q;
`endif
    if (state_q != IDLE && shift_enable) pcnt_d = tick ? '0 : pcnt_q + PW'(1);
    if (accept) begin
      sr_d   = shifted(parallel_in);
      so_d   = first_bit(parallel_in);
      bcnt_d = '0;
      pcnt_d = '0;
`ifdef FLEX_PTS_PARITY_EN
      par_d  = ^parallel_in;
`endif
    end else if (state_q == SHIFT && tick && !last_bit) begin
      sr_d   = shifted(sr_q);
      so_d   = first_bit(sr_q);
      bcnt_d = bcnt_q + BW'(1);
    end else if (state_q == SHIFT && tick) begin
`ifdef FLEX_PTS_PARITY_EN
      so_d   = par_q;
`else
      so_d   = IDLE_LEVEL;
      done_d = 1'b1;
`endif
    end
`ifdef FLEX_PTS_PARITY_EN
    else if (state_q == PARITY && tick) begin
      so_d   = IDLE_LEVEL;
      done_d = 1'b1;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= {NUM_BITS{IDLE_LEVEL}};
      bcnt_q <= '0;
      pcnt_q <= '0;
      so_q   <= IDLE_LEVEL;
      done_q <= 1'b0;
`ifdef FLEX_PTS_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      sr_q   <= sr_d;
      bcnt_q <= bcnt_d;
      pcnt_q <= pcnt_d;
      so_q   <= so_d;
      done_q <= done_d;
`ifdef FLEX_PTS_PARITY_EN
      par_q  <= par_d;
`endif
    end
  end
endmodule

// File: doc/flex_pts_serializer.md
FLEX_PTS_SERIALIZER -- requirements
Module: flex_pts_serializer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_BITS, 8: data word width, legal range 2..32.
- SHIFT_MSB, 1: 1 = MSB first, 0 = LSB first.
- CLKS_PER_BIT, 4: clock cycles each bit is held, legal range 1..256.
- IDLE_LEVEL, 1: serial_out level when not transmitting.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock; all state changes on the rising edge.
- rst, in, 1: reset, synchronous and active-high.
- load_valid, in, 1: parallel_in holds a word to send.
- load_ready, out, 1: block can accept a word.
- parallel_in, in, NUM_BITS: word to serialise.
- shift_enable, in, 1: advance enable; low stalls transmission.
- serial_out, out, 1: registered serial data.
- busy, out, 1: a word is in flight.
- done, out, 1: one-cycle pulse at word completion.

Function
REQ-003 The FSM SHALL have states IDLE and SHIFT, plus PARITY when FLEX_PTS_PARITY_EN is defined.
REQ-004 A word SHALL be accepted on a rising edge where load_valid=1 and load_ready=1; load_ready SHALL be 1 exactly when the state is IDLE and rst=0.
REQ-005 On acceptance:
- parallel_in SHALL be captured into an internal NUM_BITS shift register.
- The state SHALL become SHIFT.
- serial_out SHALL present the first bit (MSB if SHIFT_MSB=1, else LSB) in the very next cycle.
REQ-006 In SHIFT, a bit counter (ceil(log2(NUM_BITS)) bits) and a period counter (ceil(log2(CLKS_PER_BIT)) bits, minimum 1) SHALL control bit timing:
- The period counter SHALL increment only on cycles with shift_enable=1.
- When the period counter reaches CLKS_PER_BIT-1 with shift_enable=1, it SHALL wrap to 0 and the next bit SHALL be driven.
REQ-007 With shift_enable held at 1, bit i SHALL be driven during cycles 1+i*CLKS_PER_BIT through (i+1)*CLKS_PER_BIT after the accept edge.
REQ-008 When shift_enable=0, serial_out and both counters SHALL hold their values; stall length SHALL be unbounded.
REQ-009 When the period of the last data bit completes:
- Without parity, the state SHALL return to IDLE and serial_out SHALL return to IDLE_LEVEL.
- With parity, the state SHALL move to PARITY.
REQ-010 done SHALL be 1 for exactly one cycle: the first cycle back in IDLE. busy SHALL be 1 in every non-IDLE state.
REQ-011 load_valid asserted while busy=1 SHALL be ignored; the word in flight SHALL be unaffected and parallel_in SHALL not be sampled.
REQ-012 A new word MAY be accepted in the same cycle that done=1, giving back-to-back words with no extra idle cycle.
REQ-013 Bits vacated in the internal shift register SHALL be filled with IDLE_LEVEL.
REQ-014 With CLKS_PER_BIT=1, each bit SHALL last exactly one enabled cycle.

Reset
REQ-015 While rst=1 at a rising edge:
- The state SHALL become IDLE, both counters 0, shift register all IDLE_LEVEL.
- serial_out SHALL be IDLE_LEVEL, busy 0, done 0.
- load_ready SHALL be 0.
REQ-016 Reset asserted mid-word SHALL abort the word with no done pulse; load_ready SHALL return to 1 in the first cycle after rst falls.

Configuration
REQ-017 Macro FLEX_PTS_PARITY_EN:
- Defined: after the last data bit, PARITY SHALL drive the even-parity bit (XOR of the captured word) for CLKS_PER_BIT enabled cycles, with stall rules identical to SHIFT, before the return to IDLE.
- Undefined: no PARITY state and no parity logic SHALL exist.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- NUM_BITS=8, SHIFT_MSB=1, CLKS_PER_BIT=2, no parity, load 0xA5, shift_enable=1 -> serial_out 1,0,1,0,0,1,0,1, each for 2 cycles, over cycles 1-16; done=1 in cycle 17.
- Same setup with SHIFT_MSB=0, load 0x01 -> serial_out 1 in cycles 1-2, then 0 in cycles 3-16.
- Load 0xFF, shift_enable=0 for cycles 5-9 -> every bit boundary delayed by 5 cycles; done=1 in cycle 22.
- Load 0x3C, rst pulsed in cycle 6 -> serial_out=1 and busy=0 with no done pulse; load_ready=1 in the first cycle after rst falls.
- FLEX_PTS_PARITY_EN defined, load 0xA5 -> parity bit 0 in cycles 17-18; done=1 in cycle 19. Load 0xA4 -> parity bit 1.
- Second word held valid during done -> accepted at the done edge; its first bit is driven in the next cycle.
